// File: rtl/pipelined_shifter.sv
// ============================================================================
//  Module      : pipelined_shifter
//  Description : Log-depth barrel shifter (SLL/SRL/SRA/ROR), one register per
//                shift-amount bit, valid/ready flow control with bubble collapse.
//                Define PIPELINED_SHIFTER_ROTATE_EN to enable ROR on mode 11.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipelined_shifter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_shamt,
  input  logic [1:0]                 in_mode,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_zero
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int LAST    = SHAMT_W - 1;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b10;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
  localparam logic [1:0] MODE_ROR = 2'b11;
`endif

  logic [SHAMT_W-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]   data_q  [SHAMT_W];
  logic [WIDTH-1:0]   data_d  [SHAMT_W];
  logic [SHAMT_W-1:0] shamt_q [SHAMT_W];
  logic [SHAMT_W-1:0] shamt_d [SHAMT_W];
  logic [1:0]         mode_q  [SHAMT_W];
  logic [1:0]         mode_d  [SHAMT_W];
  logic [TAG_W-1:0]   tag_q   [SHAMT_W];
  logic [TAG_W-1:0]   tag_d   [SHAMT_W];

  logic [SHAMT_W-1:0] stage_ready;

  logic [SHAMT_W-1:0] prev_valid;
  logic [WIDTH-1:0]   prev_data  [SHAMT_W];
  logic [SHAMT_W-1:0] prev_shamt [SHAMT_W];
  logic [1:0]         prev_mode  [SHAMT_W];
  logic [TAG_W-1:0]   prev_tag   [SHAMT_W];

  // Fixed-distance shift of 2^k; SRA keeps the MSB, which is the original sign.
  function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] din,
                                                   input logic [1:0] mode,
                                                   input int k);
    logic [WIDTH-1:0] r;
    int amt;
    amt = 1 << k;
    case (mode)
      MODE_SLL: r = din << amt;
      MODE_SRA: r = $signed(din) >>> amt;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
      MODE_ROR: r = (din >> amt) | (din << (WIDTH - amt));
`endif
      default:  r = din >> amt;
    endcase
    return r;
  endfunction

  // A stage may load if it or any stage downstream of it has a hole, or the
  // consumer drains the last stage this cycle.
  always_comb begin
    logic all_full;
    all_full    = 1'b1;
    stage_ready = '0;
    for (int k = LAST; k >= 0; k--) begin
      all_full       = all_full & valid_q[k];
      stage_ready[k] = out_ready | ~all_full;
    end
  end

  always_comb begin
    prev_valid[0] = in_valid;
    prev_data[0]  = in_data;
    prev_shamt[0] = in_shamt;
    prev_mode[0]  = in_mode;
    prev_tag[0]   = in_tag;
    for (int k = 1; k < SHAMT_W; k++) begin
      prev_valid[k] = valid_q[k-1];
      prev_data[k]  = data_q[k-1];
      prev_shamt[k] = shamt_q[k-1];
      prev_mode[k]  = mode_q[k-1];
      prev_tag[k]   = tag_q[k-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (stage_ready[k]) begin
        valid_d[k] = prev_valid[k];
        data_d[k]  = prev_shamt[k][k] ? shift_stage(prev_data[k], prev_mode[k], k)
                                      : prev_data[k];
        shamt_d[k] = prev_shamt[k];
        mode_d[k]  = prev_mode[k];
        tag_d[k]   = prev_tag[k];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < SHAMT_W; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        mode_q[k]  <= '0;
        tag_q[k]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
    end
  end

  assign in_ready  = stage_ready[0];
  assign out_valid = valid_q[LAST];
  assign out_data  = data_q[LAST];
  assign out_tag   = tag_q[LAST];
  assign out_zero  = ~|out_data;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_shifter.sv
// ============================================================================
//  Module      : tb_pipelined_shifter
//  Description : Randomized scoreboard bench for pipelined_shifter plus
//                directed latency, backpressure, reset and 8-bit checks.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipelined_shifter;

  localparam int W  = 32;
  localparam int TW = 5;
  localparam int SW = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [W-1:0]  in_data, out_data;
  logic [SW-1:0] in_shamt;
  logic [1:0]    in_mode;
  logic [TW-1:0] in_tag, out_tag;

  logic          in_valid8, in_ready8, out_valid8, out_zero8;
  logic [7:0]    in_data8, out_data8;
  logic [2:0]    in_shamt8;
  logic [1:0]    in_mode8;
  logic [TW-1:0] in_tag8, out_tag8;

  always #5 clock = ~clock;

  pipelined_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_zero(out_zero)
  );

  pipelined_shifter #(.WIDTH(8), .TAG_W(TW)) dut8 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .in_shamt(in_shamt8), .in_mode(in_mode8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(1'b1), .out_data(out_data8),
    .out_tag(out_tag8), .out_zero(out_zero8)
  );

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  bit            hold_seen = 1'b0;
  logic [W-1:0]  hold_data;
  logic [TW-1:0] hold_tag;

  // Whole-word reference: shifts by the full amount in one step.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s,
                                         input logic [1:0] m);
    logic [2*W-1:0] wide;
    case (m)
      2'b00: return d << s;
      2'b01: return d >> s;
      2'b10: begin wide = {{W{d[W-1]}}, d}; wide = wide >> s; return wide[W-1:0]; end
      default: begin
`ifdef PIPELINED_SHIFTER_ROTATE_EN
        wide = {d, d}; wide = wide >> s; return wide[W-1:0];
`else
        return d >> s;
`endif
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, ahead of the transferring rising edge.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      hold_seen = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        e.data = model(in_data, int'(in_shamt), in_mode);
        e.tag  = in_tag;
        sb.push_back(e);
      end
      if (out_valid && hold_seen) begin
        check("stall_data_stable", out_data, hold_data);
        check("stall_tag_stable", out_tag, hold_tag);
      end
      hold_seen = out_valid && !out_ready;
      hold_data = out_data;
      hold_tag  = out_tag;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h required=none", out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_tag", out_tag, e.tag);
          check("out_zero", out_zero, e.data == '0);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input int s, input logic [1:0] m,
                      input logic [TW-1:0] t);
    int n = 0;
    in_data = d; in_shamt = s[SW-1:0]; in_mode = m; in_tag = t; in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && n < 200) begin @(negedge clock); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic measure(input logic [W-1:0] d, input int s, input logic [1:0] m,
                         input logic [TW-1:0] t, output int n);
    n = 0; out_ready = 1'b1;
    in_data = d; in_shamt = s[SW-1:0]; in_mode = m; in_tag = t; in_valid = 1'b1;
    do begin
      @(posedge clock); #1; in_valid = 1'b0; n++;
      @(negedge clock);
    end while (!out_valid && n < 20);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (sb.size() != 0 && n < 500) begin @(posedge clock); #1; n++; end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int          n, acc;
    logic [W-1:0] exp3 [3];
    reset = 1'b1; out_ready = 1'b1;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0;
    in_valid8 = 1'b0; in_data8 = '0; in_shamt8 = '0; in_mode8 = '0; in_tag8 = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_zero", out_zero, 1);
    check("rst_in_ready", in_ready, 1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Single SRA with latency measurement
    measure(32'h8000_0000, 4, 2'b10, 5'd3, n);
    check("latency_sra", n, 5);
    check("sra_data", out_data, 32'hF800_0000);
    check("sra_tag", out_tag, 3);
    check("sra_zero", out_zero, 0);
    @(posedge clock); #1;
    drain();

    // Back-to-back operations
    exp3[0] = 32'h8000_0000;
    exp3[1] = 32'h0000_0001;
`ifdef PIPELINED_SHIFTER_ROTATE_EN
    exp3[2] = 32'h8000_0000;
`else
    exp3[2] = 32'h0000_0000;
`endif
    send(32'h0000_0001, 31, 2'b00, 5'd10);
    send(32'h8000_0000, 31, 2'b01, 5'd11);
    send(32'h0000_0001, 1, 2'b11, 5'd12);
    n = 0;
    @(negedge clock);
    while (!out_valid && n < 20) begin @(negedge clock); n++; end
    for (int i = 0; i < 3; i++) begin
      check("b2b_valid", out_valid, 1);
      check("b2b_data", out_data, exp3[i]);
      if (i == 2) check("b2b_zero", out_zero, exp3[2] == '0);
      @(negedge clock);
    end
    @(posedge clock); #1;
    drain();

    // Backpressure: fill with tags while the consumer stalls
    out_ready = 1'b0; acc = 0; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_tag = acc[TW-1:0]; in_data = $urandom; in_shamt = SW'($urandom); in_mode = 2'($urandom);
      @(negedge clock);
      if (in_ready) acc++;
      @(posedge clock); #1;
    end
    check("bp_accepted", acc, 5);
    @(negedge clock);
    check("bp_in_ready_low", in_ready, 0);
    @(posedge clock); #1;
    out_ready = 1'b1;
    n = 0;
    while (acc < 7 && n < 50) begin
      in_tag = acc[TW-1:0];
      @(negedge clock);
      if (in_ready) acc++;
      @(posedge clock); #1;
      n++;
    end
    in_valid = 1'b0;
    drain();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = $urandom;
      in_shamt  = (i % 17 == 0) ? SW'(0) : (i % 19 == 0) ? SW'(31) : SW'($urandom);
      in_mode   = 2'($urandom);
      in_tag    = TW'($urandom);
      out_ready = ($urandom % 3) != 0;
      @(posedge clock); #1;
    end
    drain();

    // Reset with three operations in flight
    send(32'h1234_5678, 3, 2'b00, 5'd20);
    send(32'h8765_4321, 5, 2'b10, 5'd21);
    send(32'hFFFF_0000, 7, 2'b01, 5'd22);
    #1 reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_zero", out_zero, 1);
    check("midrst_in_ready", in_ready, 1);
    sb.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("post_rst_no_stale", out_valid, 0);
    end
    @(posedge clock); #1;
    measure(32'h0000_00F0, 4, 2'b01, 5'd7, n);
    check("post_rst_latency", n, 5);
    check("post_rst_data", out_data, 32'h0000_000F);
    @(posedge clock); #1;
    drain();

    // 8-bit build: SRA 0x90 by 7
    in_data8 = 8'h90; in_shamt8 = 3'd7; in_mode8 = 2'b10; in_tag8 = 5'd9; in_valid8 = 1'b1;
    n = 0;
    do begin
      @(posedge clock); #1; in_valid8 = 1'b0; n++;
      @(negedge clock);
    end while (!out_valid8 && n < 20);
    check("w8_latency", n, 3);
    check("w8_data", out_data8, 8'hFF);
    check("w8_tag", out_tag8, 9);
    @(posedge clock); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
